// File: rtl/rv32i_writeback_unit_if.sv
// Bus between the MEM stage / data memory (master) and the writeback unit (slave).
// Handshake: an instruction moves when in_valid && in_ready at a rising clk edge;
// in_valid may be held regardless of in_ready, and the fields are only sampled on that edge.
interface rv32i_writeback_unit_if #(
  parameter int DATA_W    = 32,
  parameter int INSTRET_W = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_reg_write;
  logic [4:0]           in_rd_addr;
  logic [1:0]           in_wb_sel;
  logic [DATA_W-1:0]    in_alu_result;
  logic [DATA_W-1:0]    in_pc_plus4;
  logic [2:0]           in_funct3;
  logic                 dmem_rvalid;
  logic [DATA_W-1:0]    dmem_rdata;
  logic                 reg_write;
  logic [4:0]           rd_addr;
  logic [DATA_W-1:0]    rd_data;
  logic                 retire;
  logic                 load_fault;
  logic [INSTRET_W-1:0] instret;

  modport master (
    output in_valid, in_reg_write, in_rd_addr, in_wb_sel, in_alu_result,
           in_pc_plus4, in_funct3, dmem_rvalid, dmem_rdata,
    input  in_ready, reg_write, rd_addr, rd_data, retire, load_fault, instret
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd_addr, in_wb_sel, in_alu_result,
           in_pc_plus4, in_funct3, dmem_rvalid, dmem_rdata,
    output in_ready, reg_write, rd_addr, rd_data, retire, load_fault, instret
  );
endinterface

// File: rtl/rv32i_writeback_unit.sv
// rv32i writeback stage: selects ALU / PC+4 / load data for the register file write
// port, extracts and extends load lanes, flags load faults and counts retirements.
module rv32i_writeback_unit #(
  parameter int DATA_W    = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  rv32i_writeback_unit_if.slave  wb,
  output logic                   dbg_state
);

  typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

  localparam logic [1:0] SEL_PC4  = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;

  state_t            state;
  logic [4:0]        ld_rd;
  logic [2:0]        ld_funct3;
  logic [1:0]        ld_off;
  logic              ld_we;
  logic              in_fault;
  logic [DATA_W-1:0] byte_word;
  logic [DATA_W-1:0] half_word;
  logic [DATA_W-1:0] load_value;

  assign wb.in_ready = (state == IDLE);
  assign dbg_state   = state;

  // Misaligned halfword/word accesses and unused funct3 codes are faults.
  always_comb begin
    in_fault = 1'b1;
    case (wb.in_funct3)
      3'b000, 3'b100: in_fault = 1'b0;
      3'b001, 3'b101: in_fault = wb.in_alu_result[0];
      3'b010:         in_fault = |wb.in_alu_result[1:0];
      default:        in_fault = 1'b1;
    endcase
  end

  always_comb begin
    byte_word  = wb.dmem_rdata >> {ld_off, 3'b000};
    half_word  = wb.dmem_rdata >> {ld_off[1], 4'b0000};
    load_value = wb.dmem_rdata;
    case (ld_funct3)
      3'b000:  load_value = {{(DATA_W-8){byte_word[7]}}, byte_word[7:0]};
      3'b100:  load_value = {{(DATA_W-8){1'b0}}, byte_word[7:0]};
      3'b001:  load_value = {{(DATA_W-16){half_word[15]}}, half_word[15:0]};
      3'b101:  load_value = {{(DATA_W-16){1'b0}}, half_word[15:0]};
      default: load_value = wb.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wb.reg_write  <= 1'b0;
      wb.retire     <= 1'b0;
      wb.load_fault <= 1'b0;
      wb.rd_addr    <= '0;
      wb.rd_data    <= '0;
      wb.instret    <= '0;
      ld_rd         <= '0;
      ld_funct3     <= '0;
      ld_off        <= '0;
      ld_we         <= 1'b0;
    end else begin
      wb.reg_write  <= 1'b0;
      wb.retire     <= 1'b0;
      wb.load_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (wb.in_valid) begin
            if (wb.in_wb_sel == SEL_LOAD) begin
              if (in_fault) begin
                wb.load_fault <= 1'b1;
              end else begin
                ld_rd     <= wb.in_rd_addr;
                ld_funct3 <= wb.in_funct3;
                ld_off    <= wb.in_alu_result[1:0];
                ld_we     <= wb.in_reg_write;
                state     <= WAIT_LOAD;
              end
            end else begin
              // Reserved wb_sel 11 falls through to the ALU result.
              wb.retire    <= 1'b1;
              wb.reg_write <= wb.in_reg_write && (wb.in_rd_addr != 5'd0);
              wb.rd_addr   <= wb.in_rd_addr;
              wb.rd_data   <= (wb.in_wb_sel == SEL_PC4) ? wb.in_pc_plus4 : wb.in_alu_result;
              wb.instret   <= wb.instret + INSTRET_W'(1);
            end
          end
        end
        WAIT_LOAD: begin
          if (wb.dmem_rvalid) begin
            wb.retire    <= 1'b1;
            wb.reg_write <= ld_we && (ld_rd != 5'd0);
            wb.rd_addr   <= ld_rd;
            wb.rd_data   <= load_value;
            wb.instret   <= wb.instret + INSTRET_W'(1);
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
